pc_stack: RTL
=============

Name: pc_stack

Overview:
Parametrised program counter with a hardware return-address stack (RAS) for subroutine call/return.
- Supports reset, stall, load, increment, call (push return address and jump) and return (pop into PC).
- Sits between the instruction decoder and instruction ROM address; successor to the plain 16-bit PC.
- Reports stack occupancy and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 16: PC and stack entry width in bits.
- DEPTH, 8: RAS entries. Must be a power of two, at least 2.
- RESET_VECTOR, 0: PC value after reset.
- STEP, 1: increment amount for INC and for return-address computation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  global enable; low = stall, all state held.
- LOAD  in  1  jump: PC <= IN.
- INC  in  1  PC <= PC + STEP.
- CALL  in  1  push PC + STEP, then PC <= IN.
- RET  in  1  PC <= top of stack, pop.
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW.
- IN  in  WIDTH  jump/call target.
- OUT  out  WIDTH  current PC (registered).
- COUNT  out  $clog2(DEPTH+1)  valid stack entries, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH (combinational from COUNT).
- EMPTY  out  1  COUNT == 0 (combinational from COUNT).
- OVERFLOW  out  1  sticky: a CALL was made while FULL.
- UNDERFLOW  out  1  sticky: a RET was made while EMPTY.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): OUT=RESET_VECTOR, COUNT=0, OVERFLOW=0, UNDERFLOW=0, stack pointer=0. Stack contents are don't-care. EMPTY=1 and FULL=0 during and after reset.
- All outputs are registered except FULL and EMPTY. Every operation has 1-cycle latency: the new OUT is visible after the edge.
- Per-edge priority: RESET > !EN > (CALL&RET) > RET > CALL > LOAD > INC > hold.
- EN=0: OUT, stack, COUNT and flags all held. CLR_ERR is also ignored.
- CALL&RET together: OUT <= IN, stack and COUNT unchanged (tail call). No flag change.
- RET, COUNT>0: OUT <= stack[top], pointer decrements, COUNT decrements.
- RET, COUNT==0: OUT unchanged, UNDERFLOW <= 1, stack unchanged.
- CALL, COUNT<DEPTH: push (OUT+STEP) mod 2^WIDTH, OUT <= IN, COUNT increments.
- CALL, COUNT==DEPTH: the stack is circular. Push overwrites the oldest entry, COUNT stays at DEPTH, OUT <= IN, OVERFLOW <= 1.
  - A later DEPTH RETs return the most recent DEPTH addresses.
  - The (DEPTH+1)th RET underflows.
- LOAD: OUT <= IN. INC: OUT <= (OUT+STEP) mod 2^WIDTH. Both wrap silently, with no flag.
- LOAD or INC asserted together with CALL or RET is ignored; CALL/RET wins.
- CLR_ERR with EN=1 clears both flags. If a new error occurs on the same edge, the set wins (flag ends at 1).
- Stack pointer arithmetic is modulo DEPTH.

Test Plan:
- Reset/increment (defaults): assert RESET asynchronously mid-cycle -> OUT=0, COUNT=0, EMPTY=1 immediately. Release, INC for 3 cycles -> OUT=3. Set OUT=0xFFFF via LOAD, then INC -> OUT=0x0000, no flags.
- Call/return nesting: OUT=0x0010, CALL IN=0x0100 -> OUT=0x0100, COUNT=1. CALL IN=0x0200 -> COUNT=2. RET -> OUT=0x0101. RET -> OUT=0x0011, COUNT=0, EMPTY=1.
- Overflow wrap (DEPTH=8): 9 CALLs from PCs 0,1,...,8 (IN=n+1) -> OVERFLOW=1, COUNT=8, FULL=1. 8 RETs -> OUT = 9,8,...,2. 9th RET -> OUT holds at 2, UNDERFLOW=1.
- Stall and priority: EN=0 with CALL=1 -> OUT and COUNT unchanged. EN=1 with CALL=RET=LOAD=1, IN=0x0ABC -> OUT=0x0ABC, COUNT unchanged. LOAD+INC with IN=0x0050 -> OUT=0x0050.
- Flag clear: with UNDERFLOW=1, CLR_ERR alone -> 0. CLR_ERR together with RET while EMPTY -> UNDERFLOW stays 1.
- Reset mid-stack: COUNT=5, then RESET pulse -> COUNT=0, flags 0, OUT=RESET_VECTOR. A following RET -> UNDERFLOW=1, OUT unchanged.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter with a circular return-address stack for call/return.
// Every operation takes effect on the next rising edge; no backpressure, EN=0 stalls all state.
module pc_stack #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       LOAD,
  input  logic                       INC,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic                       CLR_ERR,
  input  logic [WIDTH-1:0]           IN,
  output logic [WIDTH-1:0]           OUT,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int unsigned      PW      = $clog2(DEPTH);
  localparam int unsigned      CW      = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  // ptr_q points at the next free slot; when full it also points at the oldest entry.
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PW-1:0]    ptr_dec;
  logic [WIDTH-1:0] ret_addr;
  logic             full;

  assign ptr_dec  = ptr_q - PW'(1);
  assign ret_addr = pc_q + STEP_W;
  assign full     = (cnt_q == DEPTH_C);

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (EN) begin
      if (CLR_ERR) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (CALL && RET) begin
        pc_d = IN;
      end else if (RET) begin
        if (cnt_q != '0) begin
          pc_d  = stack_q[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (CALL) begin
        push  = 1'b1;
        pc_d  = IN;
        ptr_d = ptr_q + PW'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end else if (LOAD) begin
        pc_d = IN;
      end else if (INC) begin
        pc_d = pc_q + STEP_W;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge CLK) begin
    if (push) stack_q[ptr_q] <= ret_addr;
  end

  assign OUT       = pc_q;
  assign COUNT     = cnt_q;
  assign FULL      = full;
  assign EMPTY     = (cnt_q == '0);
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule
